// File: rtl/ahb3lite_irq_master_pkg.sv
// ahb3lite_irq_master_pkg: shared FSM states, AHB constants and index width
package ahb3lite_irq_master_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
    localparam int         IDX_W           = 10;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-set-bit finder with valid flag
module irq_prio_enc #(
    parameter int N = 32,
    parameter int W = 10
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);
    assign valid = |req;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end
endmodule

// File: rtl/ahb3lite_irq_master.sv
// ahb3lite_irq_master: IRQ rising edges become AHB3-Lite message writes; IRQ_MASTER_MASK_EN adds a MASK port
module ahb3lite_irq_master
    import ahb3lite_irq_master_pkg::*;
#(
    parameter int          IRQ_CNT       = 240,
    parameter logic [31:0] MSG_ADDR      = 32'h0000_0000,
    parameter logic [31:0] MSG_DATA_BASE = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [IRQ_CNT-1:0] IRQ,
`ifdef IRQ_MASTER_MASK_EN
    input  logic [IRQ_CNT-1:0] MASK,
`endif
    output logic [31:0]        HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [3:0]         HPROT,
    output logic               HMASTLOCK,
    output logic [31:0]        HWDATA,
    input  logic [31:0]        HRDATA,
    input  logic               HREADY,
    input  logic               HRESP,
    output logic               BUSY,
    output logic               ERR,
    output logic [IDX_W-1:0]   ERR_IDX
);
    state_t             state;
    logic [IRQ_CNT-1:0] irq_q, pending, clr, eligible;
    logic [IDX_W-1:0]   cur_idx, sel_idx;
    logic               sel_valid;
    logic               unused_hrdata;

    assign unused_hrdata = ^HRDATA;
    assign HSIZE         = HSIZE_WORD;
    assign HBURST        = HBURST_SINGLE;
    assign HPROT         = HPROT_DATA_PRIV;
    assign HMASTLOCK     = 1'b0;
    assign BUSY          = (|pending) || (state != IDLE);
`ifdef IRQ_MASTER_MASK_EN
    assign eligible = pending & ~MASK;
`else
    assign eligible = pending;
`endif
    assign clr = (state == ADDR && HREADY) ? IRQ_CNT'(1) << cur_idx : '0;

    irq_prio_enc #(.N(IRQ_CNT), .W(IDX_W)) u_enc (
        .req   (eligible),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // irq_q resets high so lines already asserted out of reset are not treated as edges
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            irq_q   <= '1;
            pending <= '0;
        end else begin
            irq_q   <= IRQ;
            pending <= (pending & ~clr) | (IRQ & ~irq_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= IDLE;
            cur_idx <= '0;
            ERR     <= 1'b0;
            ERR_IDX <= '0;
            HTRANS  <= HTRANS_IDLE;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
        end else begin
            ERR <= 1'b0;
            case (state)
                IDLE: if (sel_valid) begin
                    state   <= ADDR;
                    cur_idx <= sel_idx;
                    HTRANS  <= HTRANS_NONSEQ;
                    HADDR   <= MSG_ADDR;
                    HWRITE  <= 1'b1;
                end
                ADDR: if (HREADY) begin
                    state  <= DATA;
                    HTRANS <= HTRANS_IDLE;
                    HADDR  <= '0;
                    HWRITE <= 1'b0;
                    HWDATA <= MSG_DATA_BASE | 32'(cur_idx);
                end
                DATA: if (HREADY) begin
                    state  <= IDLE;
                    HWDATA <= '0;
                    ERR    <= HRESP;
                    if (HRESP) ERR_IDX <= cur_idx;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb3lite_irq_master.sv
// tb_ahb3lite_irq_master: directed scenarios plus randomized traffic against a message-level model
module tb_ahb3lite_irq_master;
    localparam int          N  = 240;
    localparam logic [31:0] MA = 32'h4000_1000;
    localparam logic [31:0] MB = 32'hA500_0000;

    logic         CLK = 1'b0;
    logic         RESETn;
    logic [N-1:0] IRQ;
    logic [N-1:0] MASK;
    logic [31:0]  HADDR, HWDATA, HRDATA;
    logic [1:0]   HTRANS;
    logic         HWRITE, HMASTLOCK, HREADY, HRESP, BUSY, ERR;
    logic [2:0]   HSIZE, HBURST;
    logic [3:0]   HPROT;
    logic [9:0]   ERR_IDX;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    ahb3lite_irq_master #(.IRQ_CNT(N), .MSG_ADDR(MA), .MSG_DATA_BASE(MB)) dut (
        .CLK(CLK), .RESETn(RESETn), .IRQ(IRQ),
`ifdef IRQ_MASTER_MASK_EN
        .MASK(MASK),
`endif
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .BUSY(BUSY), .ERR(ERR), .ERR_IDX(ERR_IDX)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // model: pending set of lines, plus the message currently on the bus (phase 0 none, 1 address, 2 data)
    bit [N-1:0] m_q, m_pend, m_rise, m_elig;
    int  m_ph, m_idx, m_eidx;
    bit  m_err, armed;

    initial begin
        armed = 1'b0;
        forever begin
            @(negedge CLK);
            if (armed) begin
                chk("htrans", HTRANS, m_ph == 1 ? 2 : 0);
                chk("haddr", HADDR, m_ph == 1 ? MA : 0);
                chk("hwrite", HWRITE, m_ph == 1);
                chk("hwdata", HWDATA, m_ph == 2 ? (MB | m_idx) : 0);
                chk("busy", BUSY, (m_pend != 0) || (m_ph != 0));
                chk("err", ERR, m_err);
                chk("err_idx", ERR_IDX, m_eidx);
                chk("consts", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
            end
            if (!RESETn) begin
                m_q = '1; m_pend = '0; m_ph = 0; m_idx = 0; m_err = 0; m_eidx = 0; armed = 1'b1;
            end else begin
                m_rise = IRQ & ~m_q;
                m_q    = IRQ;
                m_err  = 1'b0;
                m_elig = m_pend;
`ifdef IRQ_MASTER_MASK_EN
                m_elig = m_pend & ~MASK;
`endif
                if (m_ph == 0) begin
                    if (m_elig != 0) begin m_ph = 1; m_idx = lowest(m_elig); end
                end else if (m_ph == 1) begin
                    if (HREADY) begin m_pend[m_idx] = 1'b0; m_ph = 2; end
                end else if (HREADY) begin
                    m_ph = 0; m_err = HRESP;
                    if (HRESP) m_eidx = m_idx;
                end
                m_pend |= m_rise;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int k;
        RESETn = 1'b0; IRQ = '0; IRQ[100] = 1'b1; MASK = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        cyc(3);
        chk("rst_htrans", HTRANS, 0); chk("rst_busy", BUSY, 0); chk("rst_err_idx", ERR_IDX, 0);
        RESETn = 1'b1;
        cyc(3);
        chk("high_out_of_reset_busy", BUSY, 0);
        IRQ = '0;
        cyc(2);
        // single event on line 5
        IRQ[5] = 1'b1; cyc(1); IRQ[5] = 1'b0; cyc(1);
        chk("t5_htrans", HTRANS, 2'b10); chk("t5_haddr", HADDR, MA);
        cyc(1);
        chk("t5_hwdata", HWDATA, MB | 32'h5); chk("t5_busy_data", BUSY, 1);
        cyc(1);
        chk("t5_busy_done", BUSY, 0);
        cyc(2);
        // simultaneous 40 and 3
        IRQ[40] = 1'b1; IRQ[3] = 1'b1; cyc(1); IRQ[40] = 1'b0; IRQ[3] = 1'b0; cyc(1);
        chk("t3_htrans", HTRANS, 2'b10);
        cyc(1); chk("t3_hwdata", HWDATA, MB | 32'h3);
        cyc(1); chk("t3_gap", HTRANS, 2'b00);
        cyc(1); chk("t40_htrans", HTRANS, 2'b10);
        cyc(1); chk("t40_hwdata", HWDATA, MB | 32'h28);
        cyc(3);
        // two address-phase wait states on line 11
        IRQ[11] = 1'b1; cyc(1); IRQ[11] = 1'b0; cyc(1);
        HREADY = 1'b0; cyc(1);
        chk("ws_htrans1", HTRANS, 2'b10); chk("ws_haddr1", HADDR, MA);
        cyc(1);
        chk("ws_htrans2", HTRANS, 2'b10); chk("ws_hwrite2", HWRITE, 1);
        HREADY = 1'b1; cyc(1);
        chk("ws_hwdata", HWDATA, MB | 32'd11);
        cyc(1); chk("ws_busy", BUSY, 0);
        cyc(2);
        // line 7 re-edges on the cycle its address phase is accepted
        IRQ[7] = 1'b1; cyc(1); IRQ[7] = 1'b0; cyc(1); IRQ[7] = 1'b1; cyc(1);
        chk("re7_hwdata1", HWDATA, MB | 32'h7);
        IRQ[7] = 1'b0; cyc(2);
        chk("re7_htrans2", HTRANS, 2'b10);
        cyc(1); chk("re7_hwdata2", HWDATA, MB | 32'h7);
        cyc(1); chk("re7_busy", BUSY, 0);
        cyc(2);
        // two-cycle error response on line 9
        IRQ[9] = 1'b1; cyc(1); IRQ[9] = 1'b0; cyc(2);
        HREADY = 1'b0; HRESP = 1'b1; cyc(1);
        chk("e9_err_wait", ERR, 0); chk("e9_hwdata_held", HWDATA, MB | 32'h9);
        HREADY = 1'b1; cyc(1);
        chk("e9_err", ERR, 1); chk("e9_err_idx", ERR_IDX, 9); chk("e9_busy", BUSY, 0);
        HRESP = 1'b0; cyc(1);
        chk("e9_err_pulse", ERR, 0); chk("e9_err_idx_held", ERR_IDX, 9); chk("e9_no_retry", HTRANS, 0);
        cyc(2);
`ifdef IRQ_MASTER_MASK_EN
        MASK[2] = 1'b1; IRQ[2] = 1'b1; cyc(1); IRQ[2] = 1'b0; cyc(4);
        chk("mask_busy", BUSY, 1); chk("mask_htrans", HTRANS, 0);
        MASK[2] = 1'b0; cyc(1);
        chk("unmask_htrans", HTRANS, 2'b10);
        cyc(1); chk("unmask_hwdata", HWDATA, MB | 32'h2);
        cyc(2);
`endif
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin k = $urandom_range(0, N - 1); IRQ[k] = ~IRQ[k]; end
            if ($urandom_range(0, 5) == 0) begin k = $urandom_range(0, 7); IRQ[k] = ~IRQ[k]; end
            HREADY = $urandom_range(0, 3) != 0;
            HRESP  = $urandom_range(0, 9) == 0;
            RESETn = $urandom_range(0, 599) != 0;
            cyc(1);
        end
        RESETn = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        cyc(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
